// File: rtl/key_pulse_pkg.sv
// key_pulse_pkg
//   Shared definitions for the multi-channel key pulse generator:
//   edge-mode selector values and the per-channel debounce state type.
package key_pulse_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } deb_state_e;

endpackage

// File: rtl/key_pulse_channel.sv
// key_pulse_channel
//   One key channel: input synchroniser, debounce FSM with stability
//   counter, edge qualification and retriggerable pulse stretcher.
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset, clears all state
//   key_i    - raw asynchronous key level
//   enable_i - pulse-generation enable, sampled on the accepting edge
//   pulse_o  - registered edge pulse, PULSE_CYCLES wide (extends on reload)
//   level_o  - registered debounced key level
module key_pulse_channel
  import key_pulse_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int PULSE_CYCLES    = 1,
  parameter int EDGE_MODE       = EDGE_RISE
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  input  logic enable_i,
  output logic pulse_o,
  output logic level_o
);

  // A zero-cycle debounce still needs a legal (unused) counter width.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int PW    = $clog2(PULSE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  deb_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   event_c;
  logic                   qual_c;
  logic [PW-1:0]          pcnt_q, pcnt_d;
  logic                   pulse_q;

  assign sync = sync_q[SYNC_STAGES-1];

  // Debounce: the counter tracks consecutive cycles of disagreement; the
  // level flips on the edge after it has seen DEBOUNCE_CYCLES of them.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    event_c = 1'b0;
    if (DEBOUNCE_CYCLES == 0) begin
      state_d = ST_STABLE;
      cnt_d   = '0;
      level_d = sync;
      event_c = (sync != level_q);
    end else begin
      unique case (state_q)
        ST_STABLE: begin
          if (sync != level_q) begin
            state_d = ST_CHECK;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_CHECK: begin
          if (sync == level_q) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
            level_d = ~level_q;
            event_c = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // The old level tells the direction of the accepted change.
  always_comb begin
    qual_c = 1'b0;
    if (enable_i && event_c) begin
      if (EDGE_MODE == EDGE_BOTH)
        qual_c = 1'b1;
      else if (EDGE_MODE == EDGE_FALL)
        qual_c = level_q;
      else
        qual_c = ~level_q;
    end
  end

  // A qualifying event reloads the counter, so overlapping pulses merge.
  always_comb begin
    pcnt_d = pcnt_q;
    if (qual_c)
      pcnt_d = PW'(PULSE_CYCLES);
    else if (pcnt_q != '0)
      pcnt_d = pcnt_q - PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pcnt_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], key_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pcnt_q  <= pcnt_d;
      pulse_q <= (pcnt_d != '0);
    end
  end

  assign pulse_o = pulse_q;
  assign level_o = level_q;

endmodule

// File: rtl/key_pulse_generator.sv
// key_pulse_generator
//   Multi-channel debounced key edge-pulse generator. Each bit of key_in is
//   handled by an independent key_pulse_channel.
// Ports:
//   clk       - sole clock
//   rst       - synchronous active-high reset
//   key_in    - raw asynchronous key levels, one per channel
//   enable    - global pulse-generation enable
//   pulse_out - per-channel edge pulses
//   key_level - per-channel debounced stable levels
module key_pulse_generator
  import key_pulse_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int PULSE_CYCLES    = 1,
  parameter int EDGE_MODE       = EDGE_RISE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] key_in,
  input  logic                enable,
  output logic [CHANNELS-1:0] pulse_out,
  output logic [CHANNELS-1:0] key_level
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    key_pulse_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .PULSE_CYCLES   (PULSE_CYCLES),
      .EDGE_MODE      (EDGE_MODE)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .key_i   (key_in[g]),
      .enable_i(enable),
      .pulse_o (pulse_out[g]),
      .level_o (key_level[g])
    );
  end

endmodule

// File: tb/tb_key_pulse_generator.sv
// Directed bench for key_pulse_generator: four instances share stimulus and
// differ in edge mode / pulse width (rise P3, fall P3, both P3, both P8).
module tb_key_pulse_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] key_in;
  logic [1:0] p_rise, l_rise, p_fall, l_fall, p_both, l_both, p_rel, l_rel;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  key_pulse_generator #(.CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
                        .PULSE_CYCLES(3), .EDGE_MODE(0)) dut_rise (
    .clk(clk), .rst(rst), .key_in(key_in), .enable(enable),
    .pulse_out(p_rise), .key_level(l_rise));

  key_pulse_generator #(.CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
                        .PULSE_CYCLES(3), .EDGE_MODE(1)) dut_fall (
    .clk(clk), .rst(rst), .key_in(key_in), .enable(enable),
    .pulse_out(p_fall), .key_level(l_fall));

  key_pulse_generator #(.CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
                        .PULSE_CYCLES(3), .EDGE_MODE(2)) dut_both (
    .clk(clk), .rst(rst), .key_in(key_in), .enable(enable),
    .pulse_out(p_both), .key_level(l_both));

  key_pulse_generator #(.CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
                        .PULSE_CYCLES(8), .EDGE_MODE(2)) dut_rel (
    .clk(clk), .rst(rst), .key_in(key_in), .enable(enable),
    .pulse_out(p_rel), .key_level(l_rel));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    key_in = 2'b00;
    enable = 1'b1;
    repeat (20) step();
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    key_in = 2'b00;
    enable = 1'b0;
    repeat (3) step();
    vectors++;
    if ({p_rise, l_rise, p_fall, l_fall, p_both, l_both, p_rel, l_rel} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0000",
               {p_rise, l_rise, p_fall, l_fall, p_both, l_both, p_rel, l_rel});
    end
    rst    = 1'b0;
    enable = 1'b1;
    repeat (5) step();
    vectors++;
    if ({p_rise, l_rise, p_both, l_both} !== 8'h0) begin
      errors++;
      $display("FAIL idle_outputs: got %h expected 00", {p_rise, l_rise, p_both, l_both});
    end
  endtask

  task automatic test_clean_press();
    logic [1:0] exp_p, exp_l;
    settle();
    key_in = 2'b01;
    for (int n = 1; n <= 12; n++) begin
      step();
      exp_l = (n >= 7) ? 2'b01 : 2'b00;
      exp_p = (n >= 7 && n <= 9) ? 2'b01 : 2'b00;
      vectors++;
      if (l_rise !== exp_l) begin
        errors++;
        $display("FAIL press_level edge %0d: got %b expected %b", n, l_rise, exp_l);
      end
      vectors++;
      if (p_rise !== exp_p) begin
        errors++;
        $display("FAIL press_pulse edge %0d: got %b expected %b", n, p_rise, exp_p);
      end
      vectors++;
      if (p_fall !== 2'b00) begin
        errors++;
        $display("FAIL press_fallmode_pulse edge %0d: got %b expected 00", n, p_fall);
      end
    end
  endtask

  task automatic test_bounce();
    logic [1:0] exp_p, exp_l;
    int e;
    settle();
    for (int c = 0; c <= 24; c++) begin
      if (c < 8) key_in = ((c / 2) % 2 == 0) ? 2'b01 : 2'b00;
      else       key_in = 2'b01;
      step();
      e = c + 1;
      exp_l = (e >= 15) ? 2'b01 : 2'b00;
      exp_p = (e >= 15 && e <= 17) ? 2'b01 : 2'b00;
      vectors++;
      if (l_rise !== exp_l) begin
        errors++;
        $display("FAIL bounce_level edge %0d: got %b expected %b", e, l_rise, exp_l);
      end
      vectors++;
      if (p_rise !== exp_p) begin
        errors++;
        $display("FAIL bounce_pulse edge %0d: got %b expected %b", e, p_rise, exp_p);
      end
    end
  endtask

  task automatic test_edge_modes();
    logic [1:0] exp_r, exp_f, exp_b, exp_lb;
    int e;
    settle();
    for (int c = 0; c <= 24; c++) begin
      key_in = (c < 10) ? 2'b01 : 2'b00;
      step();
      e = c + 1;
      exp_r  = (e >= 7 && e <= 9) ? 2'b01 : 2'b00;
      exp_f  = (e >= 17 && e <= 19) ? 2'b01 : 2'b00;
      exp_b  = exp_r | exp_f;
      exp_lb = (e >= 7 && e < 17) ? 2'b01 : 2'b00;
      vectors++;
      if (p_both !== exp_b) begin
        errors++;
        $display("FAIL both_pulse edge %0d: got %b expected %b", e, p_both, exp_b);
      end
      vectors++;
      if (p_fall !== exp_f) begin
        errors++;
        $display("FAIL fall_pulse edge %0d: got %b expected %b", e, p_fall, exp_f);
      end
      vectors++;
      if (p_rise !== exp_r) begin
        errors++;
        $display("FAIL rise_pulse edge %0d: got %b expected %b", e, p_rise, exp_r);
      end
      vectors++;
      if (l_both !== exp_lb) begin
        errors++;
        $display("FAIL both_level edge %0d: got %b expected %b", e, l_both, exp_lb);
      end
    end
  endtask

  task automatic test_reload();
    logic [1:0] exp_rel, exp_b;
    int e;
    settle();
    for (int c = 0; c <= 24; c++) begin
      key_in = (c < 6) ? 2'b01 : 2'b00;
      step();
      e = c + 1;
      exp_rel = (e >= 7 && e <= 20) ? 2'b01 : 2'b00;
      exp_b   = ((e >= 7 && e <= 9) || (e >= 13 && e <= 15)) ? 2'b01 : 2'b00;
      vectors++;
      if (p_rel !== exp_rel) begin
        errors++;
        $display("FAIL reload_pulse edge %0d: got %b expected %b", e, p_rel, exp_rel);
      end
      vectors++;
      if (p_both !== exp_b) begin
        errors++;
        $display("FAIL min_spacing_pulse edge %0d: got %b expected %b", e, p_both, exp_b);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [1:0] exp_p, exp_l;
    settle();
    key_in = 2'b01;
    repeat (8) step();
    vectors++;
    if (p_rise !== 2'b01) begin
      errors++;
      $display("FAIL midpulse_before_rst: got %b expected 01", p_rise);
    end
    rst = 1'b1;
    step();
    vectors++;
    if ({p_rise, l_rise, p_rel, l_rel} !== 8'h0) begin
      errors++;
      $display("FAIL midpulse_rst_outputs: got %h expected 00", {p_rise, l_rise, p_rel, l_rel});
    end
    rst = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      exp_l = (n >= 7) ? 2'b01 : 2'b00;
      exp_p = (n >= 7 && n <= 9) ? 2'b01 : 2'b00;
      vectors++;
      if (l_rise !== exp_l) begin
        errors++;
        $display("FAIL post_rst_level edge %0d: got %b expected %b", n, l_rise, exp_l);
      end
      vectors++;
      if (p_rise !== exp_p) begin
        errors++;
        $display("FAIL post_rst_pulse edge %0d: got %b expected %b", n, p_rise, exp_p);
      end
    end
  endtask

  task automatic test_enable();
    logic [1:0] exp_p, exp_l;
    settle();
    enable = 1'b0;
    key_in = 2'b01;
    for (int n = 1; n <= 12; n++) begin
      step();
      exp_l = (n >= 7) ? 2'b01 : 2'b00;
      vectors++;
      if (l_rise !== exp_l) begin
        errors++;
        $display("FAIL disabled_level edge %0d: got %b expected %b", n, l_rise, exp_l);
      end
      vectors++;
      if ({p_rise, p_both} !== 4'b0000) begin
        errors++;
        $display("FAIL disabled_pulse edge %0d: got %b expected 0000", n, {p_rise, p_both});
      end
    end
    enable = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      vectors++;
      if (p_rise !== 2'b00) begin
        errors++;
        $display("FAIL reenable_no_retro cycle %0d: got %b expected 00", n, p_rise);
      end
    end
    key_in = 2'b00;
    repeat (15) step();
    key_in = 2'b01;
    for (int n = 1; n <= 12; n++) begin
      step();
      exp_p = (n >= 7 && n <= 9) ? 2'b01 : 2'b00;
      vectors++;
      if (p_rise !== exp_p) begin
        errors++;
        $display("FAIL reenabled_pulse edge %0d: got %b expected %b", n, p_rise, exp_p);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp_p, exp_l;
    settle();
    key_in = 2'b11;
    for (int n = 1; n <= 10; n++) begin
      step();
      exp_l = (n >= 7) ? 2'b11 : 2'b00;
      exp_p = (n >= 7 && n <= 9) ? 2'b11 : 2'b00;
      vectors++;
      if (l_rise !== exp_l) begin
        errors++;
        $display("FAIL simul_level edge %0d: got %b expected %b", n, l_rise, exp_l);
      end
      vectors++;
      if (p_rise !== exp_p) begin
        errors++;
        $display("FAIL simul_pulse edge %0d: got %b expected %b", n, p_rise, exp_p);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    key_in = 2'b00;
    test_reset();
    test_clean_press();
    test_bounce();
    test_edge_modes();
    test_reload();
    test_reset_mid_pulse();
    test_enable();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
